// File: rtl/fnd_pkg.sv
// Shared definitions for the 7-segment display bus: glyph table, digit codes
// and the receiver FSM encoding. Used by both the display encoder and receiver.
package fnd_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK = 4'hE;
  localparam logic [3:0] CODE_INV   = 4'hF;

  typedef enum logic [1:0] {
    ST_SETTLE   = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_CHG = 2'd2
  } fnd_state_e;

  // Active-low enables: exactly one bit low selects one position.
  function automatic logic is_one_cold(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, ~v[i]};
    return (n == 3'd1);
  endfunction

endpackage

// File: rtl/fnd_scan_rx_if.sv
// Display bus as seen by the receiver, plus debug visibility of its FSM state
// and the set of positions captured in the current frame.
interface fnd_scan_rx_if;
  import fnd_pkg::*;

  // Level bus with no valid/ready: the scanner may change enables, segments
  // and dp at any time; the receiver qualifies data purely by stability.
  logic [5:0] i_seg_enb;
  logic [6:0] i_seg;
  logic       i_seg_dp;
  fnd_state_e dbg_state;
  logic [5:0] dbg_seen;

  modport master (output i_seg_enb, i_seg, i_seg_dp, input dbg_state, dbg_seen);
  modport slave  (input i_seg_enb, i_seg, i_seg_dp, output dbg_state, dbg_seen);

endinterface

// File: rtl/fnd_seg2num.sv
// Combinational segment-pattern to digit-code decoder; legal is low for any
// pattern that is neither a digit glyph nor blank.
module fnd_seg2num
  import fnd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       legal
);

  always_comb begin
    legal = 1'b1;
    code  = CODE_INV;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code  = CODE_INV;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fnd_scan_rx.sv
// Display-bus receiver: synchronizes the multiplexed bus, captures each stable
// position, reassembles six-digit frames and recovers minutes/seconds.
module fnd_scan_rx
  import fnd_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 16,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  fnd_scan_rx_if.slave  bus,
  output logic [23:0]   o_digit,
  output logic [5:0]    o_dp,
  output logic [5:0]    o_sec,
  output logic [5:0]    o_min,
  output logic          o_time_vld,
  output logic          o_frame_vld,
  output logic          o_err_pat,
  output logic          o_err_enb,
  output logic          o_stale
);

  // Sample layout: {enb[5:0], seg[6:0], dp}
  logic [13:0] sync1_q, sync2_q, prev_q;
  fnd_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  seen_q, seen_d;
  logic [23:0] shd_dig_q, shd_dig_d;
  logic [5:0]  shd_dp_q, shd_dp_d;
  logic [23:0] digit_q, digit_d;
  logic [5:0]  dp_q, dp_d;
  logic [5:0]  sec_q, sec_d;
  logic [5:0]  min_q, min_d;
  logic        tvld_q, tvld_d;
  logic [31:0] stale_q, stale_d;

  logic        samp_chg, capture, bad_enb, frame_done;
  logic [5:0]  samp_enb, pos_oh, seen_new;
  logic [3:0]  cap_code;
  logic        cap_legal;
  logic [3:0]  f0, f1, f2, f3, f4, f5;
  logic        time_ok;

  assign samp_enb = sync2_q[13:8];
  assign pos_oh   = ~samp_enb;
  assign samp_chg = (sync2_q != prev_q);

  fnd_seg2num u_seg2num (
    .seg   (sync2_q[7:1]),
    .code  (cap_code),
    .legal (cap_legal)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    bad_enb = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (samp_chg) begin
          cnt_d = 8'd0;
        end else if (cnt_q == 8'(STABLE_CYC - 1)) begin
          if (is_one_cold(samp_enb)) begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end else if (samp_enb == 6'h3F) begin
            state_d = ST_WAIT_CHG;
          end else begin
            bad_enb = 1'b1;
            state_d = ST_WAIT_CHG;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        // One capture per stable interval: wait here until the bus moves.
        if (samp_chg) begin
          cnt_d   = 8'd0;
          state_d = ST_SETTLE;
        end
      end
    endcase
  end

  always_comb begin
    shd_dig_d  = shd_dig_q;
    shd_dp_d   = shd_dp_q;
    seen_d     = seen_q;
    seen_new   = seen_q | pos_oh;
    frame_done = 1'b0;
    if (capture) begin
      for (int k = 0; k < 6; k++) begin
        if (pos_oh[k]) begin
          shd_dig_d[4*k +: 4] = cap_code;
          shd_dp_d[k]         = sync2_q[0];
        end
      end
      if (seen_new == 6'h3F) begin
        frame_done = 1'b1;
        seen_d     = 6'h00;
      end else begin
        seen_d = seen_new;
      end
    end
  end

  // Frame fields are taken from the shadow including the current capture.
  assign f0 = shd_dig_d[3:0];
  assign f1 = shd_dig_d[7:4];
  assign f2 = shd_dig_d[11:8];
  assign f3 = shd_dig_d[15:12];
  assign f4 = shd_dig_d[19:16];
  assign f5 = shd_dig_d[23:20];
  assign time_ok = (f0 <= 4'd9) && (f2 <= 4'd9) && (f1 <= 4'd5) && (f3 <= 4'd5)
                && (f4 == CODE_BLANK) && (f5 == CODE_BLANK);

  always_comb begin
    digit_d = digit_q;
    dp_d    = dp_q;
    sec_d   = sec_q;
    min_d   = min_q;
    tvld_d  = tvld_q;
    if (frame_done) begin
      digit_d = shd_dig_d;
      dp_d    = shd_dp_d;
      tvld_d  = time_ok;
      sec_d   = time_ok ? ({2'b00, f1} * 6'd10 + {2'b00, f0}) : 6'd0;
      min_d   = time_ok ? ({2'b00, f3} * 6'd10 + {2'b00, f2}) : 6'd0;
    end
  end

  // Capture wins over reaching the threshold on the same cycle.
  always_comb begin
    stale_d = stale_q;
    if (capture)                 stale_d = 32'd0;
    else if (stale_q != TIMEOUT) stale_d = stale_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 14'h3FFF;
      sync2_q   <= 14'h3FFF;
      prev_q    <= 14'h3FFF;
      state_q   <= ST_SETTLE;
      cnt_q     <= 8'd0;
      seen_q    <= 6'h00;
      shd_dig_q <= 24'hFFFFFF;
      shd_dp_q  <= 6'h00;
      digit_q   <= 24'hFFFFFF;
      dp_q      <= 6'h00;
      sec_q     <= 6'd0;
      min_q     <= 6'd0;
      tvld_q    <= 1'b0;
      stale_q   <= 32'd0;
    end else begin
      sync1_q   <= {bus.i_seg_enb, bus.i_seg, bus.i_seg_dp};
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      shd_dig_q <= shd_dig_d;
      shd_dp_q  <= shd_dp_d;
      digit_q   <= digit_d;
      dp_q      <= dp_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      tvld_q    <= tvld_d;
      stale_q   <= stale_d;
    end
  end

  assign o_digit       = digit_q;
  assign o_dp          = dp_q;
  assign o_sec         = sec_q;
  assign o_min         = min_q;
  assign o_time_vld    = tvld_q;
  assign o_frame_vld   = frame_done;
  assign o_err_pat     = capture & ~cap_legal;
  assign o_err_enb     = bad_enb;
  assign o_stale       = (stale_q == TIMEOUT);
  assign bus.dbg_state = state_q;
  assign bus.dbg_seen  = seen_q;

endmodule

// File: tb/tb_fnd_scan_rx.sv
// Bench for fnd_scan_rx: directed display-bus scans with hand-computed frames
// queued for a monitor that checks each o_frame_vld.
module tb_fnd_scan_rx;
  import fnd_pkg::*;

  localparam int STB = 16;
  localparam int TMO = 8000;
  localparam int W   = 43;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  fnd_scan_rx_if bus();
  logic [23:0] o_digit;
  logic [5:0]  o_dp, o_sec, o_min;
  logic        o_time_vld, o_frame_vld, o_err_pat, o_err_enb, o_stale;

  fnd_scan_rx #(.STABLE_CYC(STB), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_digit     (o_digit),
    .o_dp        (o_dp),
    .o_sec       (o_sec),
    .o_min       (o_min),
    .o_time_vld  (o_time_vld),
    .o_frame_vld (o_frame_vld),
    .o_err_pat   (o_err_pat),
    .o_err_enb   (o_err_enb),
    .o_stale     (o_stale)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int frames = 0;
  int pat_errs = 0;
  int enb_errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [23:0] dig, input logic [5:0] dp,
                          input logic [5:0] sec, input logic [5:0] mn, input logic tv);
    exp_q.push_back({dig, dp, sec, mn, tv});
  endtask

  // monitor: frame outputs are compared one cycle after the pulse
  logic         chk_pend = 1'b0;
  logic [W-1:0] chk_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk_pend = 1'b0;
    end else begin
      if (chk_pend) begin
        check("frame", 64'({o_digit, o_dp, o_sec, o_min, o_time_vld}), 64'(chk_exp));
        chk_pend = 1'b0;
      end
      if (o_frame_vld) begin
        frames++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got digit %0h expected no frame", o_digit);
        end else begin
          chk_exp  = exp_q.pop_front();
          chk_pend = 1'b1;
        end
      end
      if (o_err_pat) pat_errs++;
      if (o_err_enb) enb_errs++;
    end
  end

  // drivers (called at a falling edge)
  function automatic logic [6:0] code2seg(input logic [3:0] c);
    case (c)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  task automatic drive(input int pos, input logic [6:0] seg, input logic dp, input int cyc);
    bus.i_seg_enb = ~(6'b1 << pos);
    bus.i_seg     = seg;
    bus.i_seg_dp  = dp;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic blank(input int cyc);
    bus.i_seg_enb = 6'h3F;
    bus.i_seg     = SEG_BLANK;
    bus.i_seg_dp  = 1'b0;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic scan(input logic [23:0] codes, input logic [5:0] dps, input int first, input int cyc);
    for (int k = first; k < 6; k++) drive(k, code2seg(codes[4*k +: 4]), dps[k], cyc);
    blank(40);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digit"}, 64'(o_digit), 64'hFFFFFF);
    check({tag, "_dp"},    64'(o_dp), 64'd0);
    check({tag, "_sec"},   64'(o_sec), 64'd0);
    check({tag, "_min"},   64'(o_min), 64'd0);
    check({tag, "_flags"}, 64'({o_time_vld, o_frame_vld, o_err_pat, o_err_enb, o_stale}), 64'd0);
    check({tag, "_seen"},  64'(bus.dbg_seen), 64'd0);
    check({tag, "_state"}, 64'(bus.dbg_state), 64'(ST_SETTLE));
  endtask

  initial begin
    bus.i_seg_enb = 6'h3F;
    bus.i_seg     = SEG_BLANK;
    bus.i_seg_dp  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // normal frame 12:34, dp on position 2
    push_exp(24'hEE1234, 6'b000100, 6'd34, 6'd12, 1'b1);
    scan(24'hEE1234, 6'b000100, 0, 5000);
    check("frames_after_normal", 64'(frames), 64'd1);

    // glitch of SEG_8 inside stable SEG_3 on position 0
    push_exp(24'hEE0543, 6'b000000, 6'd43, 6'd5, 1'b1);
    drive(0, SEG_3, 1'b0, 100);
    drive(0, SEG_8, 1'b0, 10);
    drive(0, SEG_3, 1'b0, 100);
    scan(24'hEE0543, 6'b000000, 1, 100);
    check("glitch_no_err", 64'({pat_errs, enb_errs}), 64'd0);

    // illegal pattern on position 0
    push_exp(24'hEE321F, 6'b000000, 6'd0, 6'd0, 1'b0);
    drive(0, 7'h55, 1'b0, 100);
    scan(24'hEE3210, 6'b000000, 1, 100);
    check("pat_err_count", 64'(pat_errs), 64'd1);

    // maximum 59:59, all dp set
    push_exp(24'hEE5959, 6'b111111, 6'd59, 6'd59, 1'b1);
    scan(24'hEE5959, 6'b111111, 0, 100);

    // seconds tens digit out of range
    push_exp(24'hEE0060, 6'b000000, 6'd0, 6'd0, 1'b0);
    scan(24'hEE0060, 6'b000000, 0, 100);

    // position 4 not blank
    push_exp(24'hE10000, 6'b000000, 6'd0, 6'd0, 1'b0);
    scan(24'hE10000, 6'b000000, 0, 100);

    // illegal enable vector between captures
    push_exp(24'hEE4321, 6'b000000, 6'd21, 6'd43, 1'b1);
    drive(0, SEG_1, 1'b0, 100);
    bus.i_seg_enb = 6'b111100;
    bus.i_seg     = SEG_2;
    repeat (100) @(negedge clk);
    check("enb_err_count", 64'(enb_errs), 64'd1);
    check("enb_seen", 64'(bus.dbg_seen), 64'b000001);
    scan(24'hEE4321, 6'b000000, 1, 100);

    // reset mid-frame discards the partial frame
    drive(0, SEG_1, 1'b0, 100);
    drive(1, SEG_2, 1'b0, 100);
    drive(2, SEG_3, 1'b0, 100);
    blank(5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("mid");
    rst_n = 1'b1;
    @(negedge clk);
    scan(24'hEE0000, 6'b000000, 3, 100);
    check("no_frame_after_reset", 64'(frames), 64'd7);
    check("seen_after_reset", 64'(bus.dbg_seen), 64'b111000);
    push_exp(24'hEE0527, 6'b000000, 6'd27, 6'd5, 1'b1);
    drive(0, SEG_7, 1'b0, 100);
    drive(1, SEG_2, 1'b0, 100);
    drive(2, SEG_5, 1'b0, 100);
    blank(40);

    // staleness
    drive(0, SEG_0, 1'b0, 40);
    blank(TMO - 100);
    check("stale_before", 64'(o_stale), 64'd0);
    blank(200);
    check("stale_after", 64'(o_stale), 64'd1);
    drive(1, SEG_0, 1'b0, 40);
    check("stale_cleared", 64'(o_stale), 64'd0);
    blank(40);

    check("frame_total", 64'(frames), 64'd8);
    check("final_pat_errs", 64'(pat_errs), 64'd1);
    check("final_enb_errs", 64'(enb_errs), 64'd1);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
